// File: rtl/seq_divider_if.sv
// Handshake and result bundle for the sequential 8-by-4 divider.
`default_nettype none

interface seq_divider_if;
  logic       start_i;
  logic [7:0] dividend_i;
  logic [3:0] divisor_i;
  logic [7:0] quotient_o;
  logic [3:0] remainder_o;
  logic       busy_o;
  logic       done_o;
  logic       div_by_zero_o;

  modport master (
    output start_i, dividend_i, divisor_i,
    input  quotient_o, remainder_o, busy_o, done_o, div_by_zero_o
  );

  modport slave (
    input  start_i, dividend_i, divisor_i,
    output quotient_o, remainder_o, busy_o, done_o, div_by_zero_o
  );
endinterface

`default_nettype wire

// File: rtl/seq_divider.sv
// Restoring 8-bit by 4-bit unsigned divider, one quotient bit per clock.
`default_nettype none

module seq_divider (
  input  wire logic     clk_i,
  input  wire logic     rst_i,
  seq_divider_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q;
  logic [2:0] cnt_q;
  logic [7:0] dvd_q;
  logic [3:0] dvs_q;
  logic [3:0] rem_q;
  logic [7:0] quo_q;
  logic [7:0] quotient_q;
  logic [3:0] remainder_q;
  logic       dbz_q;
  logic       busy_q;
  logic       done_q;

  logic [4:0] partial_d;
  logic       ge_d;
  logic [3:0] rem_d;
  logic [7:0] quo_d;

  // One restoring step: the partial remainder never exceeds 2*divisor-1, so 5 bits suffice.
  always_comb begin
    partial_d = {rem_q, dvd_q[7]};
    ge_d      = (partial_d >= {1'b0, dvs_q});
    rem_d     = ge_d ? 4'(partial_d - {1'b0, dvs_q}) : partial_d[3:0];
    quo_d     = {quo_q[6:0], ge_d};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      dvd_q       <= 8'h00;
      dvs_q       <= 4'h0;
      rem_q       <= 4'h0;
      quo_q       <= 8'h00;
      quotient_q  <= 8'h00;
      remainder_q <= 4'h0;
      dbz_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // done trails the DONE state by one edge, so it lands with the FSM back in IDLE
      done_q <= (state_q == DONE);
      case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            dvd_q  <= bus.dividend_i;
            dvs_q  <= bus.divisor_i;
            rem_q  <= 4'h0;
            quo_q  <= 8'h00;
            cnt_q  <= 3'd0;
            busy_q <= 1'b1;
            if (bus.divisor_i == 4'h0) begin
              quotient_q  <= 8'hFF;
              remainder_q <= 4'h0;
              dbz_q       <= 1'b1;
              state_q     <= DONE;
            end else begin
              quotient_q  <= 8'h00;
              remainder_q <= 4'h0;
              dbz_q       <= 1'b0;
              state_q     <= RUN;
            end
          end
        end
        RUN: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          dvd_q <= {dvd_q[6:0], 1'b0};
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            quotient_q  <= quo_d;
            remainder_q <= rem_d;
            state_q     <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.quotient_o    = quotient_q;
  assign bus.remainder_o   = remainder_q;
  assign bus.div_by_zero_o = dbz_q;
  assign bus.busy_o        = busy_q;
  assign bus.done_o        = done_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: directed cases plus a shuffled sweep of every operand pair.
`timescale 1ns/1ps

module tb_seq_divider;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_divider_if bus();

  seq_divider dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0]  q;
    logic [3:0]  r;
    logic        z;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input bit ok, input longint act, input longint expv);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: actual=0x%0h expected=0x%0h (t=%0t)", name, act, expv, $time);
  endtask

  // Reference: plain integer division, with the fixed zero-divisor result.
  function automatic exp_t model(input int a, input int b, input int unsigned acc_cyc);
    exp_t e;
    if (b == 0) begin
      e.q = 8'hFF; e.r = 4'h0; e.z = 1'b1; e.cyc = acc_cyc + 1;
    end else begin
      e.q = 8'(a / b); e.r = 4'(a % b); e.z = 1'b0; e.cyc = acc_cyc + 9;
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request, on time.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      if (bus.done_o) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1'b0, 1, 0);
        end else begin
          e = sb.pop_front();
          check("result", {bus.quotient_o, bus.remainder_o, bus.div_by_zero_o} == {e.q, e.r, e.z},
                {bus.quotient_o, bus.remainder_o, bus.div_by_zero_o}, {e.q, e.r, e.z});
          check("done_cycle", cyc == e.cyc, cyc, e.cyc);
        end
      end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
        check("done_timeout", 1'b0, cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
    end
  end

  task automatic check_zero_outputs(input string tag);
    check({tag, "_quotient"}, bus.quotient_o == 8'h00, bus.quotient_o, 0);
    check({tag, "_remainder"}, bus.remainder_o == 4'h0, bus.remainder_o, 0);
    check({tag, "_dbz"}, bus.div_by_zero_o == 1'b0, bus.div_by_zero_o, 0);
    check({tag, "_busy"}, bus.busy_o == 1'b0, bus.busy_o, 0);
    check({tag, "_done"}, bus.done_o == 1'b0, bus.done_o, 0);
  endtask

  // Call at a negedge with the DUT idle; returns at the first negedge it is idle again.
  task automatic issue(input int a, input int b, input bit garble);
    bit idle_seen = 1'b0;
    bus.dividend_i = 8'(a);
    bus.divisor_i  = 4'(b);
    bus.start_i    = 1'b1;
    sb.push_back(model(a, b, cyc + 1));
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!bus.busy_o && k > 0) begin
        idle_seen = 1'b1;
        break;
      end
      if (garble) begin
        bus.start_i    = 1'($urandom_range(0, 1));
        bus.dividend_i = 8'($urandom);
        bus.divisor_i  = 4'($urandom);
      end else begin
        bus.start_i = 1'b0;
      end
    end
    bus.start_i = 1'b0;
    if (!idle_seen) check("busy_release_timeout", 1'b0, 1, 0);
  endtask

  task automatic wait_idle();
    bit idle_seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!bus.busy_o) begin
        idle_seen = 1'b1;
        break;
      end
    end
    if (!idle_seen) check("idle_wait_timeout", 1'b0, 1, 0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin : drv
    int pairs[4096];
    int busy_cycles;
    bus.start_i    = 1'b0;
    bus.dividend_i = 8'h00;
    bus.divisor_i  = 4'h0;
    rst = 1'b1;
    #2;
    check_zero_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 200/7 with a stray 50/5 request during RUN that must be dropped
    bus.dividend_i = 8'd200;
    bus.divisor_i  = 4'd7;
    bus.start_i    = 1'b1;
    sb.push_back(model(200, 7, cyc + 1));
    busy_cycles = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (bus.busy_o) busy_cycles++;
      bus.start_i = (k == 2);
      if (k == 2) begin
        bus.dividend_i = 8'd50;
        bus.divisor_i  = 4'd5;
      end
    end
    bus.start_i = 1'b0;
    check("busy_cycles_200_7", busy_cycles == 9, busy_cycles, 9);
    check("hold_quotient", bus.quotient_o == 8'h1C, bus.quotient_o, 8'h1C);
    check("hold_remainder", bus.remainder_o == 4'd4, bus.remainder_o, 4);

    issue(255, 1, 1'b0);
    issue(5, 9, 1'b0);
    issue(100, 0, 1'b0);
    check("hold_dbz", bus.div_by_zero_o == 1'b1, bus.div_by_zero_o, 1);

    // start held high: three operations accepted ten cycles apart
    bus.dividend_i = 8'd200;
    bus.divisor_i  = 4'd7;
    bus.start_i    = 1'b1;
    for (int k = 0; k < 3; k++) sb.push_back(model(200, 7, cyc + 1 + 10 * k));
    repeat (25) @(negedge clk);
    bus.start_i = 1'b0;
    wait_idle();

    // reset in the 4th RUN cycle aborts with no done pulse
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    #1;
    check_zero_outputs("midrun_reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_reset_idle", bus.busy_o == 1'b0, bus.busy_o, 0);
    issue(13, 4, 1'b0);

    // every operand pair, shuffled, with inputs and start scrambled while busy
    for (int i = 0; i < 4096; i++) pairs[i] = i;
    for (int i = 4095; i > 0; i--) begin
      int j = int'($urandom_range(0, i));
      int t = pairs[i];
      pairs[i] = pairs[j];
      pairs[j] = t;
    end
    for (int i = 0; i < 4096; i++) issue(pairs[i] >> 4, pairs[i] & 15, 1'b1);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb.size() == 0, sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
